imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory (1-cycle registered read) between the fetch
//  stage (read-only) and the program loader/debug port (read/write).
//  Sits between fetch/loader and the memory macro; owns grant, starvation control and response routing.
//  The fetch PC register is untouched: fetch holds f_req/f_addr until granted.
// PARAMETERS
//  N         32  address/data width
//  MAX_WAIT  4   consecutive denied fetch cycles before fetch wins a conflict (>=1)
//  CNT_W     16  width of conflict counter (IMEM_ARB_STATS_EN only)
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      synchronous reset, active-high
//  f_req      in   1      fetch read request; addr held stable until f_gnt
//  f_addr     in   N      fetch byte address
//  f_gnt      out  1      fetch request accepted this cycle
//  f_rvalid   out  1      fetch read data valid (1 cycle after f_gnt)
//  f_rdata    out  N      fetch read data; 0 when !f_rvalid
//  l_req      in   1      loader request; l_wr/l_addr/l_wdata held until l_gnt
//  l_wr       in   1      1=write, 0=read
//  l_addr     in   N      loader byte address
//  l_wdata    in   N      loader write data
//  l_gnt      out  1      loader request accepted this cycle
//  l_rvalid   out  1      loader read data valid (1 cycle after read grant; never for writes)
//  l_rdata    out  N      loader read data; 0 when !l_rvalid
//  mem_en     out  1      memory access strobe
//  mem_wr     out  1      memory write enable
//  mem_addr   out  N      word address = granted byte addr >> 2 (bits[1:0] ignored)
//  mem_wdata  out  N      write data (l_wdata when loader granted, else 0)
//  mem_rdata  in   N      memory read data, valid cycle after mem_en&!mem_wr
//  conflict_cnt out CNT_W cycles with f_req&l_req (IMEM_ARB_STATS_EN only)
// BEHAVIOUR
//  - Grant is combinational, same cycle as request; at most one grant per cycle.
//  - Only one requester: it is granted. Neither: mem_en=0, mem_wr=0, mem_addr=0.
//  - Conflict (f_req&l_req): loader wins unless wait_cnt==MAX_WAIT, then fetch wins.
//  - wait_cnt: +1 each cycle f_req&!f_gnt (saturates at MAX_WAIT); cleared on f_gnt or !f_req.
//  - mem_en=f_gnt|l_gnt; mem_wr=l_gnt&l_wr; addr/wdata muxed from granted port.
//  - Response owner reg: rsp_f<=f_gnt, rsp_l<=l_gnt&!l_wr; f_rvalid=rsp_f, l_rvalid=rsp_l.
//  - Back-to-back grants allowed every cycle; responses are strictly in grant order.
//  - Reset: wait_cnt=0, rsp_f=rsp_l=0, all grant/valid/mem outputs 0, conflict_cnt=0.
//  - Reset mid-operation: any response due next cycle is dropped (no rvalid after rst).
//  - Requester dropping req before gnt is legal; no state kept except wait_cnt clear.
// CONFIGURATION
//  IMEM_ARB_STATS_EN defined: conflict_cnt increments each cycle f_req&l_req, saturates
//   at 2^CNT_W-1, cleared by rst.
//  Not defined: conflict_cnt port absent; no counter logic.
// TESTING
//  1 rst=1 two cycles, all req=0 -> all outputs 0; release rst, still idle.
//  2 f_req=1 f_addr=0x10 only -> f_gnt=1, mem_addr=0x4; next cycle f_rvalid=1, f_rdata=mem_rdata.
//  3 l_req=1 l_wr=1 l_addr=0x8 l_wdata=0xDEADBEEF -> l_gnt, mem_wr=1, mem_addr=0x2; no l_rvalid.
//  4 f_req,l_req both held high, MAX_WAIT=4 -> loader granted 4 cycles, fetch on 5th, then loader.
//  5 grant f at cycle t, l read at t+1 -> f_rvalid at t+1, l_rvalid at t+2, data not swapped.
//  6 f_gnt at t, rst=1 at t+1 -> f_rvalid=0 at t+1; STATS_EN: 10 conflict cycles -> conflict_cnt=10.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port instruction memory (1-cycle registered
// read) between the fetch stage (read-only) and the loader/debug port
// (read/write). Grant is combinational. The loader wins conflicts unless
// fetch has already been denied MAX_WAIT consecutive cycles. Responses are
// routed back to the port that issued the read one cycle earlier.
// Optional feature: define IMEM_ARB_STATS_EN to add a saturating
// conflict_cnt output that counts cycles in which both ports request.
module imem_arbiter #(
  parameter int N        = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [N-1:0]     f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [N-1:0]     f_rdata,
  input  logic             l_req,
  input  logic             l_wr,
  input  logic [N-1:0]     l_addr,
  input  logic [N-1:0]     l_wdata,
  output logic             l_gnt,
  output logic             l_rvalid,
  output logic [N-1:0]     l_rdata,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic [N-1:0]     mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_r;
  logic              rsp_f_r;
  logic              rsp_l_r;
  logic              f_gnt_s;
  logic              l_gnt_s;

  // Byte address to memory word address; the two low bits select a byte
  // within the word and are not used by the memory.
  function automatic logic [N-1:0] word_addr(input logic [N-1:0] byte_addr);
    return {2'b00, byte_addr[N-1:2]};
  endfunction

  // Byte-select bits are intentionally dropped by word_addr.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[1:0], l_addr[1:0]};

  // Grant selection: single requester wins; on conflict the loader wins
  // unless fetch has reached its starvation limit. Nothing granted in reset.
  always_comb begin
    f_gnt_s = 1'b0;
    l_gnt_s = 1'b0;
    if (rst) begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
    end else if (f_req && l_req) begin
      if (wait_cnt_r == WAIT_MAX) begin
        f_gnt_s = 1'b1;
      end else begin
        l_gnt_s = 1'b1;
      end
    end else if (f_req) begin
      f_gnt_s = 1'b1;
    end else if (l_req) begin
      l_gnt_s = 1'b1;
    end else begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
    end
  end

  // Memory request mux driven from whichever port holds the grant.
  always_comb begin
    mem_en    = f_gnt_s | l_gnt_s;
    mem_wr    = l_gnt_s & l_wr;
    mem_addr  = {N{1'b0}};
    mem_wdata = {N{1'b0}};
    if (f_gnt_s) begin
      mem_addr = word_addr(f_addr);
    end else if (l_gnt_s) begin
      mem_addr  = word_addr(l_addr);
      mem_wdata = l_wdata;
    end else begin
      mem_addr  = {N{1'b0}};
      mem_wdata = {N{1'b0}};
    end
  end

  // Fetch starvation counter and response-owner flags for next-cycle data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      rsp_f_r    <= 1'b0;
      rsp_l_r    <= 1'b0;
    end else begin
      rsp_f_r <= f_gnt_s;
      rsp_l_r <= l_gnt_s & ~l_wr;
      if (f_req && !f_gnt_s) begin
        if (wait_cnt_r == WAIT_MAX) begin
          wait_cnt_r <= wait_cnt_r;
        end else begin
          wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
    end
  end

  // Response routing; a response due in a reset cycle is suppressed.
  always_comb begin
    f_gnt    = f_gnt_s;
    l_gnt    = l_gnt_s;
    f_rvalid = rsp_f_r & ~rst;
    l_rvalid = rsp_l_r & ~rst;
    f_rdata  = {N{1'b0}};
    l_rdata  = {N{1'b0}};
    if (f_rvalid) begin
      f_rdata = mem_rdata;
    end else if (l_rvalid) begin
      l_rdata = mem_rdata;
    end else begin
      f_rdata = {N{1'b0}};
      l_rdata = {N{1'b0}};
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [CNT_W-1:0] conflict_cnt_r;

  // Saturating count of cycles in which both ports request.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (f_req && l_req && (conflict_cnt_r != {CNT_W{1'b1}})) begin
      conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign conflict_cnt = conflict_cnt_r;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a reference model predicts grants and
// memory-side signals each cycle; expected read responses are queued at grant
// time and popped/compared when the response cycle arrives.
module tb_imem_arbiter;
  localparam int N        = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;

  logic          clk;
  logic          rst;
  logic          f_req;
  logic [N-1:0]  f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [N-1:0]  f_rdata;
  logic          l_req;
  logic          l_wr;
  logic [N-1:0]  l_addr;
  logic [N-1:0]  l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [N-1:0]  l_rdata;
  logic          mem_en;
  logic          mem_wr;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [CNT_W-1:0] conflict_cnt;
`endif

  imem_arbiter #(.N(N), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_wr(l_wr), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  typedef struct packed {
    logic          port_l;
    logic [N-1:0]  data;
  } rsp_t;

  rsp_t         exp_q[$];
  logic [N-1:0] mem    [0:63];
  logic [N-1:0] shadow [0:63];
  logic         mem_ready = 1'b0;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           wait_m;
  int           cnt_m;
  logic         cnt_known;
  logic         last_fg;
  int           fg_seen;

  function automatic logic [N-1:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory macro model: 1-cycle registered read, synchronous write.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_en && mem_wr) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare outputs at negedge against the model, then
  // advance the model to what the next posedge should produce.
  task automatic cycle();
    logic         exp_fg, exp_lg, has, efv, elv;
    logic [N-1:0] efd, eld, eaddr, ewdata;
    rsp_t         e;
    @(negedge clk);
    exp_fg = !rst && f_req && (!l_req || wait_m == MAX_WAIT);
    exp_lg = !rst && l_req && !exp_fg;
    has = (exp_q.size() > 0);
    e = '0;
    if (has) e = exp_q.pop_front();
    efv = has && !rst && !e.port_l;
    elv = has && !rst && e.port_l;
    efd = efv ? e.data : 32'h0;
    eld = elv ? e.data : 32'h0;
    eaddr  = exp_fg ? (f_addr >> 2) : (exp_lg ? (l_addr >> 2) : 32'h0);
    ewdata = (exp_lg && !exp_fg) ? l_wdata : 32'h0;
    check_val("f_gnt", f_gnt, exp_fg);
    check_val("l_gnt", l_gnt, exp_lg);
    check_val("mem_en", mem_en, exp_fg | exp_lg);
    check_val("mem_wr", mem_wr, exp_lg & l_wr);
    check_val("mem_addr", mem_addr, eaddr);
    check_val("mem_wdata", mem_wdata, ewdata);
    check_val("f_rvalid", f_rvalid, efv);
    check_val("l_rvalid", l_rvalid, elv);
    check_val("f_rdata", f_rdata, efd);
    check_val("l_rdata", l_rdata, eld);
`ifdef IMEM_ARB_STATS_EN
    if (cnt_known) check_val("conflict_cnt", conflict_cnt, cnt_m);
`endif
    if (f_gnt === 1'b1) fg_seen++;
    if (exp_fg) exp_q.push_back('{1'b0, shadow[f_addr[7:2]]});
    if (exp_lg && !l_wr) exp_q.push_back('{1'b1, shadow[l_addr[7:2]]});
    if (exp_lg && l_wr) shadow[l_addr[7:2]] = l_wdata;
    if (rst) wait_m = 0;
    else if (f_req && !exp_fg) wait_m = (wait_m == MAX_WAIT) ? MAX_WAIT : wait_m + 1;
    else wait_m = 0;
    if (rst) begin
      cnt_m = 0;
      cnt_known = 1'b1;
    end else if (f_req && l_req && cnt_m != (1 << CNT_W) - 1) begin
      cnt_m = cnt_m + 1;
    end
    last_fg = exp_fg;
    @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    rst = 1'b1; f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_wr = 1'b0;
    l_addr = 32'h0; l_wdata = 32'h0;
    wait_m = 0; cnt_m = 0; cnt_known = 1'b0; last_fg = 1'b0; fg_seen = 0;

    // Reset two cycles, then idle.
    cycle(); cycle();
    rst = 1'b0;
    cycle(); cycle();

    // Lone fetch read.
    f_req = 1'b1; f_addr = 32'h10;
    cycle();
    f_req = 1'b0;
    cycle();

    // Loader write, then loader read-back of the written word.
    l_req = 1'b1; l_wr = 1'b1; l_addr = 32'h8; l_wdata = 32'hDEADBEEF;
    cycle();
    l_req = 1'b0;
    cycle();
    l_req = 1'b1; l_wr = 1'b0; l_addr = 32'hB;
    cycle();
    l_req = 1'b0;
    cycle();

    // Sustained conflict: loader x4, fetch, loader x4, fetch.
    f_req = 1'b1; f_addr = 32'h20; l_req = 1'b1; l_wr = 1'b0; l_addr = 32'h8;
    fg_seen = 0;
    repeat (10) cycle();
    check_val("conflict_fetch_grants", fg_seen, 2);
    f_req = 1'b0; l_req = 1'b0;
    cycle();

    // Fetch then loader read back-to-back: ordered, not swapped.
    f_req = 1'b1; f_addr = 32'h10;
    cycle();
    f_req = 1'b0; l_req = 1'b1; l_wr = 1'b0; l_addr = 32'h8;
    cycle();
    l_req = 1'b0;
    cycle(); cycle();

    // Reset right after a fetch grant drops the pending response.
    f_req = 1'b1; f_addr = 32'h30;
    cycle();
    f_req = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();

    // Ten conflict cycles after a fresh reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0; f_req = 1'b1; l_req = 1'b1; l_wr = 1'b0;
    f_addr = 32'h40; l_addr = 32'h44;
    repeat (10) cycle();
    f_req = 1'b0; l_req = 1'b0;
    cycle();
`ifdef IMEM_ARB_STATS_EN
    check_val("conflict_cnt_10", conflict_cnt, 10);
`endif

    // Random traffic; requesters usually hold until granted.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!(f_req && !last_fg && $urandom_range(0, 9) != 0)) begin
        f_req  = ($urandom_range(0, 2) != 0);
        f_addr = 32'($urandom_range(0, 255));
      end
      if (!(l_req && !l_gnt && $urandom_range(0, 9) != 0)) begin
        l_req   = ($urandom_range(0, 1) != 0);
        l_wr    = ($urandom_range(0, 2) == 0);
        l_addr  = 32'($urandom_range(0, 255));
        l_wdata = $urandom;
      end
      cycle();
    end
    rst = 1'b0; f_req = 1'b0; l_req = 1'b0;
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
